uart_autobaud: RTL and testbench
================================

# uart_autobaud

Auto-baud controller for the UART bit-rate generator. On request it disables the generator and measures one 0x55 sync character on the receive line. It then computes the Q(PRE_W-4).4 prescale for an 8x oversample tick and writes it to the generator's `Prescale` input. Finally it re-enables the generator. It sits between the register/config layer and the bit-rate generator, and drives the generator's `En` and `Prescale` directly.

## Interface
- `PRE_W`, 16: prescale width; the low 4 bits are fractional.
- `CNT_W`, 18: width of the measurement counters; must be ≥ PRE_W+2.
- `IDLE_CYC`, 16: consecutive high cycles on the receive line required before arming.
- `PRESCALE_RST`, 16'h0080: `Prescale` value after reset.
- `Clk`, in, 1: single clock.
- `Rst_n`, in, 1: reset, asynchronous, active-low.
- `Start`, in, 1: one-cycle pulse that starts or restarts a measurement and clears `Locked` and `Err`.
- `Rxd`, in, 1: raw receive line, asynchronous to `Clk`; synchronized internally.
- `Prescale`, out, PRE_W: drives the generator's prescale input; registered.
- `Brg_en`, out, 1: drives the generator's enable; registered.
- `Busy`, out, 1: high in any state other than IDLE.
- `Locked`, out, 1: the last measurement succeeded.
- `Err`, out, 1: the last measurement failed; sticky until the next `Start`.

## Operation
- `Rxd` passes through a 2-flop synchronizer, giving `rxs`. A falling edge is `rxs_d`=1 and `rxs`=0.
- States: IDLE, WAIT_IDLE, WAIT_START, MEASURE, CALC.
- **IDLE**
  - `Brg_en`=1 and `Busy`=0.
  - `Start` moves to WAIT_IDLE.
- **WAIT_IDLE**
  - `Brg_en`=0.
  - Count consecutive cycles with `rxs`=1; any `rxs`=0 clears the count.
  - When the count reaches IDLE_CYC, move to WAIT_START.
- **WAIT_START**
  - Wait indefinitely for a falling edge (edge 1).
  - On edge 1: clear `total` and `ivl` to 0, clear the edge counter, and move to MEASURE.
- **MEASURE**
  - `total` and `ivl` increment every cycle after edge 1.
  - On each falling edge k (k = 2..5), the measured interval is `ivl`+1 cycles, and `ivl` restarts at 0.
  - The interval at k=2 is stored as reference `I1`.
  - Each interval at k = 3..5 must satisfy |Ik − I1| ≤ I1>>3; otherwise set `Err` and go to IDLE.
  - At edge 5 the elapsed time is T = `total`+1, which is 8 bit times. Latch T and move to CALC.
  - Timeout: if `total` reaches 2^CNT_W−1 before edge 5, set `Err` and go to IDLE.
- **CALC** (one cycle)
  - Compute P = (T+2)>>2, i.e. T/4 rounded: the tick period in 1/16-cycle units.
  - If P < 16 (integer part 0) or P > 2^PRE_W−1, set `Err` and leave `Prescale` unchanged.
  - Otherwise load `Prescale` ← P[PRE_W-1:0] and set `Locked`=1.
  - Go to IDLE in both cases.
- On an error, `Prescale` keeps its previous value and the generator resumes with it.
- `Start` in any non-IDLE state restarts at WAIT_IDLE:
  - counters are cleared;
  - `Err`=0 and `Locked`=0;
  - `Brg_en` stays 0.
- `Start` in IDLE takes effect the same way.
- The arithmetic is unsigned. `total` and `ivl` are CNT_W bits wide. The tolerance compare uses CNT_W+1 bits so the subtraction cannot wrap.

## Timing
- Reset values:
  - state = IDLE
  - `Prescale` = PRESCALE_RST
  - `Brg_en` = 1
  - `Busy` = 0
  - `Locked` = 0
  - `Err` = 0
- `Start` sampled at cycle n gives `Brg_en`=0 and `Busy`=1 at n+1. `Err` and `Locked` clear at n+1.
- `Rxd` to `rxs` latency is 2 cycles. Edge detection adds 1 cycle, so all edges see the same 3-cycle latency and T is unaffected.
- The edge-5 cycle latches T. The CALC cycle follows.
- At the cycle after CALC:
  - `Prescale`, `Locked`/`Err`, `Brg_en`=1 and `Busy`=0 all update together.
  - `Prescale` is stable whenever `Brg_en` rises.
- Reset asserted mid-measurement returns all state and outputs to their reset values immediately (asynchronously).
- `Start` coinciding with a timeout or CALC: `Start` wins. `Err`, `Locked` and `Prescale` are not updated.

## Test plan
- Reset, then idle for 20 cycles: `Prescale`=16'h0080, `Brg_en`=1, `Locked`=0, `Err`=0.
- `Start`, 20 idle-high cycles, then 0x55 at 64 cycles/bit (start bit, LSB first, stop bit):
  - T=512, `Prescale`=16'h0080;
  - `Locked`=1 and `Brg_en`=1 exactly 1 cycle after the CALC cycle.
- Same sequence at 100 cycles/bit: T=800, `Prescale`=16'h00C8 (12.5 cycles/tick), `Locked`=1.
- 0x55 at 64 cycles/bit but bit 3 stretched to 90 cycles:
  - `Err`=1 at the edge that opens the bit-5 interval;
  - `Prescale` stays 16'h0080, `Brg_en` returns to 1.
- Single falling edge, then `Rxd` held low: `Err`=1 when `total` reaches 2^18−1; `Locked`=0.
- `Start` again halfway through a measurement, then a clean 0x55 at 64 cycles/bit: the restart discards the partial count and ends with `Prescale`=16'h0080 and `Locked`=1.
- `Rst_n` low mid-MEASURE: all outputs take their reset values immediately.

Source files
------------

// File: rtl/uart_autobaud.sv
// uart_autobaud
//   Measures one 0x55 sync character on Rxd and programs the bit-rate
//   generator with a Q(PRE_W-4).4 prescale for an 8x oversample tick.
//   While a measurement runs the generator is held disabled; it is
//   re-enabled with the new (or, on error, the previous) prescale.
//
// Ports
//   Clk       in   single clock
//   Rst_n     in   asynchronous active-low reset
//   Start     in   one-cycle pulse: start/restart a measurement
//   Rxd       in   raw receive line (asynchronous to Clk)
//   Prescale  out  [PRE_W-1:0] generator prescale, registered
//   Brg_en    out  generator enable, registered
//   Busy      out  high whenever not in IDLE
//   Locked    out  last measurement succeeded
//   Err       out  last measurement failed (sticky until next Start)
module uart_autobaud #(
    parameter int               PRE_W        = 16,
    parameter int               CNT_W        = 18,
    parameter int               IDLE_CYC     = 16,
    parameter logic [PRE_W-1:0] PRESCALE_RST = PRE_W'(16'h0080)
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Start,
    input  logic             Rxd,
    output logic [PRE_W-1:0] Prescale,
    output logic             Brg_en,
    output logic             Busy,
    output logic             Locked,
    output logic             Err
);

    typedef enum logic [2:0] {IDLE, WAIT_IDLE, WAIT_START, MEASURE, CALC} state_t;

    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYC - 1);
    localparam logic [CNT_W:0]   W_ONE     = (CNT_W+1)'(1);
    localparam logic [CNT_W:0]   W_TWO     = (CNT_W+1)'(2);
    localparam logic [CNT_W:0]   W_SIXTEEN = (CNT_W+1)'(16);

    state_t           state, state_nx;
    logic             rx_meta, rxs, rxs_d;
    logic [CNT_W-1:0] idle_cnt, total, ivl, i1, t_lat;
    logic [2:0]       edge_cnt;   // falling edges seen since edge 1 (inclusive)

    logic             fall;
    logic [CNT_W:0]   ivl_p1, diff, p_calc;
    logic             in_tol, p_bad, meas_fail;

    // Synchronizer plus one delay stage for edge detection; idle line is high.
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
            rxs_d   <= 1'b1;
        end else begin
            rx_meta <= Rxd;
            rxs     <= rx_meta;
            rxs_d   <= rxs;
        end
    end

    assign fall = rxs_d & ~rxs;

    // Arithmetic is one bit wider than the counters so differences and the
    // rounding add cannot wrap.
    always_comb begin
        ivl_p1 = {1'b0, ivl} + W_ONE;
        diff   = (ivl_p1 >= {1'b0, i1}) ? (ivl_p1 - {1'b0, i1}) : ({1'b0, i1} - ivl_p1);
        in_tol = diff <= {4'b0000, i1[CNT_W-1:3]};
        p_calc = ({1'b0, t_lat} + W_TWO) >> 2;
        p_bad  = (p_calc < W_SIXTEEN) || ((p_calc >> PRE_W) != '0);
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nx  = state;
        meas_fail = 1'b0;
        unique case (state)
            IDLE:       ;
            WAIT_IDLE:  if (rxs && idle_cnt == IDLE_LAST) state_nx = WAIT_START;
            WAIT_START: if (fall) state_nx = MEASURE;
            MEASURE: begin
                if (fall) begin
                    // edge_cnt is the index of the previous edge, so k = edge_cnt+1.
                    if (edge_cnt >= 3'd2 && !in_tol) begin
                        meas_fail = 1'b1;
                        state_nx  = IDLE;
                    end else if (edge_cnt == 3'd4) begin
                        state_nx = CALC;
                    end
                end else if (total == CNT_MAX) begin
                    meas_fail = 1'b1;
                    state_nx  = IDLE;
                end
            end
            CALC:       state_nx = IDLE;
            default:    state_nx = IDLE;
        endcase
        // A restart overrides whatever this cycle would otherwise have done.
        if (Start) begin
            state_nx  = WAIT_IDLE;
            meas_fail = 1'b0;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            idle_cnt <= '0;
            total    <= '0;
            ivl      <= '0;
            i1       <= '0;
            t_lat    <= '0;
            edge_cnt <= '0;
            Prescale <= PRESCALE_RST;
            Locked   <= 1'b0;
            Err      <= 1'b0;
            Brg_en   <= 1'b1;
            Busy     <= 1'b0;
        end else begin
            // Enable and busy follow the next state so they change together
            // with Prescale/Locked/Err.
            Brg_en <= (state_nx == IDLE);
            Busy   <= (state_nx != IDLE);
            if (Start) begin
                idle_cnt <= '0;
                total    <= '0;
                ivl      <= '0;
                edge_cnt <= '0;
                Locked   <= 1'b0;
                Err      <= 1'b0;
            end else begin
                unique case (state)
                    WAIT_IDLE: idle_cnt <= rxs ? idle_cnt + CNT_ONE : '0;
                    WAIT_START: begin
                        if (fall) begin
                            total    <= '0;
                            ivl      <= '0;
                            edge_cnt <= 3'd1;
                        end
                    end
                    MEASURE: begin
                        total <= total + CNT_ONE;
                        if (fall) begin
                            ivl      <= '0;
                            edge_cnt <= edge_cnt + 3'd1;
                            if (edge_cnt == 3'd1) i1    <= ivl_p1[CNT_W-1:0];
                            if (edge_cnt == 3'd4) t_lat <= total + CNT_ONE;
                        end else begin
                            ivl <= ivl + CNT_ONE;
                        end
                        if (meas_fail) Err <= 1'b1;
                    end
                    CALC: begin
                        if (p_bad) begin
                            Err <= 1'b1;
                        end else begin
                            Prescale <= p_calc[PRE_W-1:0];
                            Locked   <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_autobaud.sv
// tb_uart_autobaud
//   Scoreboard bench for uart_autobaud. Stimulus pushes the expected
//   end-of-measurement result; a monitor pops and compares whenever Busy
//   falls. Counter width is reduced so the timeout case stays short.
module tb_uart_autobaud;

    localparam int PRE_W = 12;
    localparam int CNT_W = 14;

    typedef struct {
        logic [PRE_W-1:0] pre;
        logic             locked;
        logic             err;
        int               lat;   // cycles from ref_cyc to Busy low, -1 = not checked
    } exp_t;

    logic             clk, rst_n, start, rxd;
    logic [PRE_W-1:0] prescale;
    logic             brg_en, busy, locked, err;

    int   n_chk  = 0;
    int   n_pass = 0;
    int   cyc    = 0;
    int   ref_cyc = 0;
    logic prev_busy = 1'b0;
    exp_t exp_q[$];

    uart_autobaud #(
        .PRE_W(PRE_W), .CNT_W(CNT_W), .IDLE_CYC(16), .PRESCALE_RST(12'h080)
    ) dut (
        .Clk(clk), .Rst_n(rst_n), .Start(start), .Rxd(rxd),
        .Prescale(prescale), .Brg_en(brg_en), .Busy(busy),
        .Locked(locked), .Err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (act === exp) n_pass = n_pass + 1;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Monitor: each completed (or reset-aborted) measurement pops one entry.
    always @(negedge clk) begin
        exp_t e;
        if (prev_busy && !busy) begin
            if (exp_q.size() == 0) begin
                n_chk = n_chk + 1;
                $display("FAIL unexpected_done: Busy fell at cycle %0d, no result expected", cyc);
            end else begin
                e = exp_q.pop_front();
                check("prescale", 32'(prescale), 32'(e.pre));
                check("locked",   32'(locked),   32'(e.locked));
                check("err",      32'(err),      32'(e.err));
                check("brg_en",   32'(brg_en),   32'd1);
                if (e.lat >= 0) check("done_latency", 32'(cyc - ref_cyc), 32'(e.lat));
            end
        end
        prev_busy = busy;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_busy",   32'(busy),   32'd1);
        check("start_brg_en", 32'(brg_en), 32'd0);
        check("start_locked", 32'(locked), 32'd0);
        check("start_err",    32'(err),    32'd0);
    endtask

    // Drive the first nbits of a 0x55 frame (start, LSB first, stop).
    // ref_cyc is set when the ref_edge-th falling edge is driven.
    task automatic send_sync(input int bit_len, input int nbits, input int stretch_idx,
                             input int stretch_len, input int ref_edge);
        logic [9:0] frame;
        int         edge_no;
        int         len;
        frame   = 10'b1010101010;
        edge_no = 0;
        for (int i = 0; i < nbits; i++) begin
            if (!frame[i] && rxd) begin
                edge_no = edge_no + 1;
                if (edge_no == ref_edge) ref_cyc = cyc;
            end
            rxd = frame[i];
            len = (i == stretch_idx) ? stretch_len : bit_len;
            repeat (len) @(negedge clk);
        end
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && busy; i++) @(negedge clk);
        if (busy) begin
            n_chk = n_chk + 1;
            $display("FAIL done_timeout: Busy still high after %0d cycles", budget);
        end
        idle(2);
    endtask

    task automatic run_sync(input int bit_len, input int stretch_idx, input int stretch_len,
                            input int ref_edge, input exp_t e);
        pulse_start();
        idle(20);
        exp_q.push_back(e);
        send_sync(bit_len, 10, stretch_idx, stretch_len, ref_edge);
        wait_done(200);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        rxd   = 1'b1;
        idle(3);
        rst_n = 1'b1;
        idle(20);
        check("rst_prescale", 32'(prescale), 32'h080);
        check("rst_brg_en",   32'(brg_en),   32'd1);
        check("rst_busy",     32'(busy),     32'd0);
        check("rst_locked",   32'(locked),   32'd0);
        check("rst_err",      32'(err),      32'd0);

        // 64 cycles/bit: T=512, P=514>>2=128; done 4 cycles after edge 5 is driven.
        run_sync(64, -1, 0, 5, '{12'h080, 1'b1, 1'b0, 4});
        // Bit 3 stretched to 90: edge 4 interval 154 vs 128, |26| > 16 -> error
        // right when edge 4 is seen (3 cycles after drive); Prescale kept.
        run_sync(64, 4, 90, 4, '{12'h080, 1'b0, 1'b1, 3});
        // 100 cycles/bit: T=800, P=802>>2=200=0x0C8.
        run_sync(100, -1, 0, 5, '{12'h0C8, 1'b1, 1'b0, 4});

        // Reset during MEASURE: outputs return to reset values without a clock.
        pulse_start();
        idle(20);
        send_sync(64, 4, -1, 0, 0);
        exp_q.push_back('{12'h080, 1'b0, 1'b0, -1});
        #2 rst_n = 1'b0;
        #1;
        check("arst_prescale", 32'(prescale), 32'h080);
        check("arst_brg_en",   32'(brg_en),   32'd1);
        check("arst_busy",     32'(busy),     32'd0);
        check("arst_locked",   32'(locked),   32'd0);
        check("arst_err",      32'(err),      32'd0);
        idle(2);
        rxd   = 1'b1;
        rst_n = 1'b1;
        idle(5);

        // 7 cycles/bit: T=56, P=58>>2=14 < 16 -> error in CALC, Prescale kept.
        run_sync(7, -1, 0, 5, '{12'h080, 1'b0, 1'b1, 4});
        // 8 cycles/bit: T=64, P=66>>2=16 -> smallest accepted value.
        run_sync(8, -1, 0, 5, '{12'h010, 1'b1, 1'b0, 4});

        // Single edge then line held low: edge seen 3 cycles after drive,
        // total counts 0..2^14-1 over 16384 more cycles -> timeout.
        pulse_start();
        idle(20);
        exp_q.push_back('{12'h010, 1'b0, 1'b1, 16387});
        ref_cyc = cyc;
        rxd = 1'b0;
        wait_done(17000);
        rxd = 1'b1;

        // Restart halfway through a frame, then a clean frame at 64 cycles/bit.
        pulse_start();
        idle(20);
        send_sync(64, 5, -1, 0, 0);
        rxd = 1'b1;
        run_sync(64, -1, 0, 5, '{12'h080, 1'b1, 1'b0, 4});

        idle(5);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
